// File: rtl/rd_stream_fwft.sv
`default_nettype none
// ============================================================================
// Module   : rd_stream_fwft
// Purpose  : Read-domain consumer of the async FIFO. Owns the binary/Gray
//            read pointer, fetches from the RAM's registered read port and
//            presents a first-word-fall-through valid/ready stream through a
//            2-entry output buffer. Reports fill level and almost-empty.
// Revision : 1.0 - initial release
// ============================================================================
module rd_stream_fwft #(
  parameter int DSIZE         = 8,
  parameter int ADDRSIZE      = 4,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic [DSIZE-1:0]    rdata_mem,
  output logic                ren,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                m_valid,
  output logic [DSIZE-1:0]    m_data,
  input  logic                m_ready,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                raempty
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] AE_LIMIT = PW'(AEMPTY_THRESH);

  logic [PW-1:0]    rbin;
  logic [PW-1:0]    rbin_inc;
  logic [PW-1:0]    wbin_s;
  logic [PW-1:0]    avail;
  logic             inflight;
  logic [1:0]       bcnt;
  logic [1:0]       bcnt_next;
  logic [1:0]       push_slot;
  logic [2:0]       occ_next;
  logic             pop;
  logic [DSIZE-1:0] buf0;
  logic [DSIZE-1:0] buf1;

  // Gray-to-binary conversion of the synchronized write pointer
  always_comb begin
    wbin_s = '0;
    for (int i = 0; i < PW; i++) begin
      wbin_s[i] = ^(rq2_wptr >> i);
    end
  end

  // Issue control, occupancy bookkeeping and status flags
  always_comb begin
    avail     = wbin_s - rbin;
    rbin_inc  = rbin + PW'(1);
    pop       = m_valid & m_ready;
    // occ_next is exactly the buffer count after this edge; a fetch is only
    // issued while that leaves room for the word it brings back.
    occ_next  = {1'b0, bcnt} + {2'b00, inflight} - {2'b00, pop};
    bcnt_next = occ_next[1:0];
    push_slot = bcnt - {1'b0, pop};
    ren       = (avail != '0) && (occ_next < 3'd2);
    rlevel    = avail + PW'(inflight) + PW'(bcnt);
    raempty   = (rlevel <= AE_LIMIT);
  end

  assign raddr   = rbin[ADDRSIZE-1:0];
  assign m_valid = (bcnt != 2'd0);
  assign m_data  = buf0;

  // Read pointer (binary and Gray) advance together; inflight marks a pending RAM word
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin     <= '0;
      rptr     <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= ren;
      if (ren) begin
        rbin <= rbin_inc;
        rptr <= (rbin_inc >> 1) ^ rbin_inc;
      end
    end
  end

  // Two-entry output buffer: pop shifts the tail forward, the RAM word lands behind what remains
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      buf0 <= '0;
      buf1 <= '0;
      bcnt <= 2'd0;
    end else begin
      if (pop) begin
        buf0 <= buf1;
      end
      if (inflight) begin
        if (push_slot == 2'd0) begin
          buf0 <= rdata_mem;
        end else begin
          buf1 <= rdata_mem;
        end
      end
      bcnt <= bcnt_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rd_stream_fwft.sv
`default_nettype none
// ============================================================================
// Module   : tb_rd_stream_fwft
// Purpose  : Directed self-checking bench for rd_stream_fwft with a
//            behavioural dual-port RAM and write-pointer driver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rd_stream_fwft;

  localparam int DSIZE    = 8;
  localparam int ADDRSIZE = 4;

  logic                rclk;
  logic                rrst_n;
  logic [ADDRSIZE:0]   rq2_wptr;
  logic [DSIZE-1:0]    rdata_mem;
  logic                ren;
  logic [ADDRSIZE-1:0] raddr;
  logic [ADDRSIZE:0]   rptr;
  logic                m_valid;
  logic [DSIZE-1:0]    m_data;
  logic                m_ready;
  logic [ADDRSIZE:0]   rlevel;
  logic                raempty;

  logic [DSIZE-1:0] ram [0:15];
  logic [4:0]       wbin;
  int               passed;
  int               failed;
  int               total;

  rd_stream_fwft #(.DSIZE(8), .ADDRSIZE(4), .AEMPTY_THRESH(2)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rq2_wptr  (rq2_wptr),
    .rdata_mem (rdata_mem),
    .ren       (ren),
    .raddr     (raddr),
    .rptr      (rptr),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .rlevel    (rlevel),
    .raempty   (raempty)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  // Registered RAM read port
  always @(posedge rclk) begin
    if (ren) rdata_mem <= ram[raddr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [4:0] gray2bin(input logic [4:0] g);
    logic [4:0] b;
    b[4] = g[4];
    for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic write_word(input logic [7:0] d);
    ram[wbin[3:0]] = d;
    wbin = wbin + 5'd1;
    rq2_wptr = gray(wbin);
  endtask

  task automatic do_reset();
    rrst_n = 1'b0;
    m_ready = 1'b0;
    wbin = 5'd0;
    rq2_wptr = 5'd0;
    tick();
    tick();
    rrst_n = 1'b1;
    tick();
  endtask

  initial begin
    int got;
    int gaps;
    int rencnt;
    bit started;
    int wcnt;
    logic [4:0] rb;

    passed = 0; failed = 0; total = 0;
    rrst_n = 1'b0; m_ready = 1'b0; wbin = 5'd0; rq2_wptr = 5'd0;
    for (int i = 0; i < 16; i++) ram[i] = 8'h00;

    // ---------------- reset state ----------------
    tick(); tick();
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_rlevel", rlevel, 0);
    check("rst_raempty", raempty, 1);
    check("rst_ren", ren, 0);
    check("rst_rptr", rptr, 0);
    rrst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_ren", ren, 0);
      check("idle_m_valid", m_valid, 0);
    end

    // ---------------- single word ----------------
    write_word(8'h5A);
    #1;
    check("single_ren_N", ren, 1);
    check("single_lvl_N", rlevel, 1);
    tick();
    check("single_valid_N1", m_valid, 0);
    check("single_lvl_N1", rlevel, 1);
    check("single_ren_N1", ren, 0);
    tick();
    check("single_valid_N2", m_valid, 1);
    check("single_data_N2", m_data, 8'h5A);
    check("single_lvl_N2", rlevel, 1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("single_valid_pop", m_valid, 0);
    check("single_lvl_pop", rlevel, 0);
    check("single_ae_pop", raempty, 1);

    // ---------------- streaming 40 words across pointer wrap ----------------
    do_reset();
    m_ready = 1'b1;
    got = 0; gaps = 0; started = 0; wcnt = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (got == 40) break;
      if (m_valid) begin
        check("stream_data", m_data, got);
        got++;
        started = 1;
      end else if (started) begin
        gaps++;
      end
      rb = gray2bin(rptr);
      while (wcnt < 40 && (5'(wbin - rb) < 5'd16)) begin
        write_word(8'(wcnt));
        wcnt++;
      end
      tick();
    end
    m_ready = 1'b0;
    check("stream_count", got, 40);
    check("stream_gaps", gaps, 0);
    check("stream_rptr_wrapped", rptr, 5'b01100);
    check("stream_lvl_end", rlevel, 0);

    // ---------------- backpressure ----------------
    do_reset();
    for (int k = 0; k < 16; k++) write_word(8'hB0 + 8'(k));
    rencnt = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (ren) rencnt++;
      tick();
      if (m_valid) check("bp_hold", m_data, 8'hB0);
    end
    check("bp_ren_count", rencnt, 2);
    check("bp_rlevel", rlevel, 16);
    check("bp_raempty", raempty, 0);
    check("bp_m_valid", m_valid, 1);
    check("bp_ren_stalled", ren, 0);
    check("bp_rptr", rptr, 5'b00011);
    m_ready = 1'b1;
    #1;
    check("bp_ren_on_pop", ren, 1);
    check("bp_first", m_data, 8'hB0);
    tick();
    check("bp_second_oldest", m_data, 8'hB1);
    check("bp_lvl_after_pop", rlevel, 15);
    got = 1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (got == 16) break;
      m_ready = cyc[0];
      #1;
      if (m_valid && m_ready) begin
        check("bp_toggle_data", m_data, 8'hB0 + 8'(got));
        got++;
      end
      tick();
    end
    m_ready = 1'b0;
    check("bp_toggle_count", got, 16);
    tick(); tick();
    check("bp_drained_valid", m_valid, 0);
    check("bp_drained_lvl", rlevel, 0);

    // ---------------- almost-empty thresholds ----------------
    do_reset();
    for (int k = 0; k < 4; k++) write_word(8'hC0 + 8'(k));
    repeat (4) tick();
    for (int i = 0; i < 5; i++) begin
      check("ae_level", rlevel, 4 - i);
      check("ae_flag", raempty, (i >= 2) ? 1 : 0);
      if (i < 4) begin
        check("ae_data", m_data, 8'hC0 + 8'(i));
        m_ready = 1'b1;
      end else begin
        m_ready = 1'b0;
      end
      tick();
    end
    m_ready = 1'b0;

    // ---------------- reset mid-stream with full output buffer ----------------
    for (int k = 0; k < 16; k++) write_word(8'hD0 + 8'(k));
    repeat (6) tick();
    check("mid_pre_valid", m_valid, 1);
    rrst_n = 1'b0;
    wbin = 5'd0;
    rq2_wptr = 5'd0;
    #1;
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_rptr", rptr, 0);
    check("mid_rst_rlevel", rlevel, 0);
    check("mid_rst_raempty", raempty, 1);
    tick();
    rrst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("mid_post_ren", ren, 0);
      check("mid_post_valid", m_valid, 0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
